// File: rtl/cmp_minmax_pkg.sv
// Shared types and default sizes for the frame min/max scheduler.
// Optional index reporting in the top is enabled by CMP_MINMAX_IDX_EN.
package cmp_minmax_pkg;

    localparam int unsigned WIDTH_DEF = 4;
    localparam int unsigned CNT_W_DEF = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CMP_MIN = 2'd1,
        CMP_MAX = 2'd2,
        REPORT  = 2'd3
    } state_e;

endpackage

// File: rtl/cmp_minmax_core.sv
// Shared unsigned magnitude comparator: less-than and equal flags.
module cmp_core #(
    parameter int unsigned WIDTH = 4
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic             o_lt_c,
    output logic             o_eq_c
);

    assign o_lt_c = (i_a < i_b);
    assign o_eq_c = (i_a == i_b);

endmodule

// File: rtl/cmp_minmax_ctrl.sv
// Frame min/max/count scheduler time-sharing one comparator between min and max checks.
// Define CMP_MINMAX_IDX_EN to add first-occurrence index outputs for min and max.
module cmp_minmax_ctrl
    import cmp_minmax_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF,
    parameter int unsigned CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_min,
    output logic [WIDTH-1:0] out_max,
    output logic [CNT_W-1:0] out_count
`ifdef CMP_MINMAX_IDX_EN
    ,
    output logic [CNT_W-1:0] out_min_idx,
    output logic [CNT_W-1:0] out_max_idx
`endif
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_e           r_state;
    state_e           w_state_nxt;
    logic             r_first;
    logic             w_first_nxt;
    logic [WIDTH-1:0] r_sample;
    logic [WIDTH-1:0] w_sample_nxt;
    logic             r_last;
    logic             w_last_nxt;
    logic [WIDTH-1:0] r_min;
    logic [WIDTH-1:0] w_min_nxt;
    logic [WIDTH-1:0] r_max;
    logic [WIDTH-1:0] w_max_nxt;
    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] w_count_nxt;
    logic             r_in_ready;
    logic             w_in_ready_nxt;
    logic             r_out_valid;
    logic             w_out_valid_nxt;
`ifdef CMP_MINMAX_IDX_EN
    logic [CNT_W-1:0] r_min_idx;
    logic [CNT_W-1:0] w_min_idx_nxt;
    logic [CNT_W-1:0] r_max_idx;
    logic [CNT_W-1:0] w_max_idx_nxt;
`endif

    logic             w_xfer;
    logic [WIDTH-1:0] w_cmp_b;
    logic             w_lt;
    logic             w_eq;

    assign w_xfer  = in_valid && r_in_ready;
    // Operand b follows the phase: running max in CMP_MAX, running min otherwise.
    assign w_cmp_b = (r_state == CMP_MAX) ? r_max : r_min;

    cmp_core #(
        .WIDTH (WIDTH)
    ) u_cmp_core (
        .i_a    (r_sample),
        .i_b    (w_cmp_b),
        .o_lt_c (w_lt),
        .o_eq_c (w_eq)
    );

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_first     <= 1'b1;
            r_sample    <= '0;
            r_last      <= 1'b0;
            r_min       <= '0;
            r_max       <= '0;
            r_count     <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
`ifdef CMP_MINMAX_IDX_EN
            r_min_idx   <= '0;
            r_max_idx   <= '0;
`endif
        end else begin
            r_state     <= w_state_nxt;
            r_first     <= w_first_nxt;
            r_sample    <= w_sample_nxt;
            r_last      <= w_last_nxt;
            r_min       <= w_min_nxt;
            r_max       <= w_max_nxt;
            r_count     <= w_count_nxt;
            r_in_ready  <= w_in_ready_nxt;
            r_out_valid <= w_out_valid_nxt;
`ifdef CMP_MINMAX_IDX_EN
            r_min_idx   <= w_min_idx_nxt;
            r_max_idx   <= w_max_idx_nxt;
`endif
        end
    end

    // Next-state and datapath update.
    always_comb begin
        w_state_nxt  = r_state;
        w_first_nxt  = r_first;
        w_sample_nxt = r_sample;
        w_last_nxt   = r_last;
        w_min_nxt    = r_min;
        w_max_nxt    = r_max;
        w_count_nxt  = r_count;
`ifdef CMP_MINMAX_IDX_EN
        w_min_idx_nxt = r_min_idx;
        w_max_idx_nxt = r_max_idx;
`endif

        case (r_state)
            IDLE: begin
                if (w_xfer) begin
                    if (r_first) begin
                        w_min_nxt   = in_data;
                        w_max_nxt   = in_data;
                        w_count_nxt = CNT_W'(1);
                        w_first_nxt = 1'b0;
`ifdef CMP_MINMAX_IDX_EN
                        w_min_idx_nxt = '0;
                        w_max_idx_nxt = '0;
`endif
                        w_state_nxt = in_last ? REPORT : IDLE;
                    end else begin
                        w_sample_nxt = in_data;
                        w_last_nxt   = in_last;
                        w_state_nxt  = CMP_MIN;
                    end
                end
            end
            CMP_MIN: begin
                if (w_lt && !w_eq) begin
                    w_min_nxt = r_sample;
`ifdef CMP_MINMAX_IDX_EN
                    // Count still holds the 0-based position of this sample here.
                    w_min_idx_nxt = r_count;
`endif
                end
                w_state_nxt = CMP_MAX;
            end
            CMP_MAX: begin
                if (!w_lt && !w_eq) begin
                    w_max_nxt = r_sample;
`ifdef CMP_MINMAX_IDX_EN
                    w_max_idx_nxt = r_count;
`endif
                end
                if (r_count != CNT_MAX) begin
                    w_count_nxt = r_count + CNT_W'(1);
                end
                w_state_nxt = r_last ? REPORT : IDLE;
            end
            REPORT: begin
                if (out_ready) begin
                    w_state_nxt = IDLE;
                    w_first_nxt = 1'b1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase

        w_in_ready_nxt  = (w_state_nxt == IDLE);
        w_out_valid_nxt = (w_state_nxt == REPORT);
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_min   = r_min;
    assign out_max   = r_max;
    assign out_count = r_count;
`ifdef CMP_MINMAX_IDX_EN
    assign out_min_idx = r_min_idx;
    assign out_max_idx = r_max_idx;
`endif

endmodule

// File: tb/tb_cmp_minmax_ctrl.sv
// Scoreboard bench for cmp_minmax_ctrl: two instances (CNT_W 8 and 2) share one stimulus stream.
module tb_cmp_minmax_ctrl;

    localparam int W   = 4;
    localparam int CW  = 8;
    localparam int CW2 = 2;

    typedef struct {
        int mn;
        int mx;
        int n;
        int mni;
        int mxi;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic [W-1:0]  in_data;
    logic          in_last;
    logic          out_ready;
    logic          in_ready,  out_valid;
    logic [W-1:0]  out_min,   out_max;
    logic [CW-1:0] out_count;
    logic          in_ready2, out_valid2;
    logic [W-1:0]  out_min2,  out_max2;
    logic [CW2-1:0] out_count2;
`ifdef CMP_MINMAX_IDX_EN
    logic [CW-1:0]  out_min_idx,  out_max_idx;
    logic [CW2-1:0] out_min_idx2, out_max_idx2;
`endif

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;
    bit   rdy_rand = 1'b0;

    always #5 clk = ~clk;

    cmp_minmax_ctrl #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_min(out_min), .out_max(out_max), .out_count(out_count)
`ifdef CMP_MINMAX_IDX_EN
        , .out_min_idx(out_min_idx), .out_max_idx(out_max_idx)
`endif
    );

    cmp_minmax_ctrl #(.WIDTH(W), .CNT_W(CW2)) dut2 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready2), .in_data(in_data), .in_last(in_last),
        .out_valid(out_valid2), .out_ready(out_ready),
        .out_min(out_min2), .out_max(out_max2), .out_count(out_count2)
`ifdef CMP_MINMAX_IDX_EN
        , .out_min_idx(out_min_idx2), .out_max_idx(out_max_idx2)
`endif
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d t=%0t", nm, act, req, $time);
        end
    endtask

    function automatic int sat(input int v, input int lim);
        return (v > lim) ? lim : v;
    endfunction

    // Reference: extrema and first-occurrence positions straight from the sample list.
    task automatic push_exp(input int s[$]);
        exp_t e;
        e.mn = s[0]; e.mx = s[0]; e.mni = 0; e.mxi = 0; e.n = s.size();
        for (int i = 1; i < s.size(); i++) begin
            if (s[i] < e.mn) begin e.mn = s[i]; e.mni = i; end
            if (s[i] > e.mx) begin e.mx = s[i]; e.mxi = i; end
        end
        exp_q.push_back(e);
    endtask

    task automatic wait_ready();
        int g = 0;
        while (!in_ready && g < 200) begin
            @(posedge clk); #1;
            g++;
        end
        if (g >= 200) chk("in_ready_timeout", 32'(in_ready), 32'd1);
    endtask

    // Presents one sample and returns #1 after the edge that transferred it.
    task automatic send_sample(input int d, input bit last);
        in_valid = 1'b1;
        in_data  = W'(d);
        in_last  = last;
        wait_ready();
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_data  = W'($urandom_range(0, 15));
    endtask

    task automatic send_frame(input int s[$]);
        push_exp(s);
        for (int i = 0; i < s.size(); i++) send_sample(s[i], i == s.size() - 1);
    endtask

    task automatic drain();
        int g = 0;
        while (exp_q.size() != 0 && g < 5000) begin
            @(posedge clk);
            g++;
        end
        #1;
        chk("drain_timeout", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic rst_check(input string nm);
        chk({nm, "_in_ready"},  32'(in_ready),   32'd1);
        chk({nm, "_in_ready2"}, 32'(in_ready2),  32'd1);
        chk({nm, "_out_valid"}, 32'(out_valid),  32'd0);
        chk({nm, "_out_min"},   32'(out_min),    32'd0);
        chk({nm, "_out_max"},   32'(out_max),    32'd0);
        chk({nm, "_out_count"}, 32'(out_count),  32'd0);
        chk({nm, "_count2"},    32'(out_count2), 32'd0);
`ifdef CMP_MINMAX_IDX_EN
        chk({nm, "_min_idx"},   32'(out_min_idx), 32'd0);
        chk({nm, "_max_idx"},   32'(out_max_idx), 32'd0);
`endif
    endtask

    // Monitor: every cycle a result is presented, compare it with the queue head.
    always @(negedge clk) begin
        if (!rst && out_valid) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_out_valid", 32'(out_valid), 32'd0);
            end else begin
                chk("out_min",    32'(out_min),    32'(exp_q[0].mn));
                chk("out_max",    32'(out_max),    32'(exp_q[0].mx));
                chk("out_count",  32'(out_count),  32'(sat(exp_q[0].n, 255)));
                chk("out_valid2", 32'(out_valid2), 32'd1);
                chk("out_min2",   32'(out_min2),   32'(exp_q[0].mn));
                chk("out_max2",   32'(out_max2),   32'(exp_q[0].mx));
                chk("out_count2", 32'(out_count2), 32'(sat(exp_q[0].n, 3)));
                chk("in_ready_in_report", 32'(in_ready), 32'd0);
`ifdef CMP_MINMAX_IDX_EN
                chk("min_idx",  32'(out_min_idx),  32'(sat(exp_q[0].mni, 255)));
                chk("max_idx",  32'(out_max_idx),  32'(sat(exp_q[0].mxi, 255)));
                chk("min_idx2", 32'(out_min_idx2), 32'(sat(exp_q[0].mni, 3)));
                chk("max_idx2", 32'(out_max_idx2), 32'(sat(exp_q[0].mxi, 3)));
`endif
                if (out_ready) void'(exp_q.pop_front());
            end
        end
    end

    // Random consumer back-pressure when enabled.
    initial begin
        forever begin
            @(posedge clk); #1;
            if (rdy_rand) out_ready = 1'($urandom_range(0, 1));
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog expired got=%0d want=0", exp_q.size());
        $fatal(1, "watchdog");
    end

    initial begin
        int fr[$];
        rst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_check("reset");
        rst = 1'b0;
        out_ready = 1'b1;

        fr = '{5, 3, 9, 3};
        send_frame(fr);
        drain();

        // Single-sample frame: result visible right after the accepting edge.
        fr = '{7};
        push_exp(fr);
        in_valid = 1'b1; in_data = 4'd7; in_last = 1'b1;
        wait_ready();
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("single_latency", 32'(out_valid), 32'd1);
        drain();

        fr = '{4, 4, 4};
        send_frame(fr);
        drain();

        // Back-pressure: result held while out_ready is low.
        out_ready = 1'b0;
        fr = '{2, 8};
        push_exp(fr);
        send_sample(2, 1'b0);
        send_sample(8, 1'b1);
        chk("multi_lat_0", 32'(out_valid), 32'd0);
        @(posedge clk); #1;
        chk("multi_lat_1", 32'(out_valid), 32'd0);
        @(posedge clk); #1;
        chk("multi_lat_2", 32'(out_valid), 32'd1);
        repeat (5) begin @(posedge clk); #1; end
        chk("held_valid", 32'(out_valid), 32'd1);
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("post_hs_in_ready",  32'(in_ready),  32'd1);
        chk("post_hs_out_valid", 32'(out_valid), 32'd0);
        chk("post_hs_popped",    32'(exp_q.size()), 32'd0);

        fr = '{1, 2, 3, 4, 0};
        send_frame(fr);
        drain();

        // Reset while the second sample is in CMP_MAX; aborted frame has no result.
        send_sample(5, 1'b0);
        send_sample(9, 1'b0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        rst_check("mid_reset");
        fr = '{6};
        send_frame(fr);
        drain();

        // Long frame exercises count saturation on both instances.
        fr = {};
        for (int i = 0; i < 300; i++) fr.push_back(int'($urandom_range(0, 15)));
        send_frame(fr);
        drain();

        rdy_rand = 1'b1;
        for (int f = 0; f < 30; f++) begin
            int len;
            len = int'($urandom_range(1, 6));
            fr = {};
            for (int i = 0; i < len; i++) fr.push_back(int'($urandom_range(0, 15)));
            send_frame(fr);
            if ($urandom_range(0, 3) == 0) repeat (int'($urandom_range(1, 4))) @(posedge clk);
            #1;
        end
        drain();
        rdy_rand = 1'b0;
        @(posedge clk); #1;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("final_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cmp_minmax_ctrl.md
# cmp_minmax_ctrl

Sequential min/max scheduler around a single shared 4-bit magnitude comparator. It accepts a framed stream of unsigned samples over a valid/ready handshake and time-multiplexes one comparator between a "vs. running min" check and a "vs. running max" check. It reports the frame's minimum, maximum and sample count on a held output handshake. It sits between a sample source and any consumer needing frame extrema, and reuses the team's less/equal comparator semantics.

## Interface
- WIDTH, 4: sample width (unsigned).
- CNT_W, 8: width of the sample counter.
- clk  input  1  clock, all logic on rising edge
- rst  input  1  reset, synchronous, active-high
- in_valid  input  1  sample present
- in_ready  output  1  block can accept; high only in IDLE
- in_data  input  WIDTH  sample value
- in_last  input  1  sample is the final one of its frame
- out_valid  output  1  result held until out_ready
- out_ready  input  1  consumer accepts result
- out_min  output  WIDTH  frame minimum
- out_max  output  WIDTH  frame maximum
- out_count  output  CNT_W  samples in frame, saturating

## Operation
- FSM states: IDLE, CMP_MIN, CMP_MAX, REPORT.
- A transfer occurs when in_valid && in_ready.
- IDLE, first sample of a frame (first flag set):
  - min = max = in_data; count = 1; first flag cleared.
  - Next state is REPORT if in_last, else IDLE.
- IDLE, subsequent sample:
  - Latch in_data into the sample register and latch in_last.
  - Next state is CMP_MIN.
- CMP_MIN: comparator a = sample, b = min. If lt && !eq, then min = sample. Next state is CMP_MAX.
- CMP_MAX:
  - Comparator a = sample, b = max. If !lt && !eq, then max = sample.
  - count increments, saturating at 2^CNT_W − 1.
  - Next state is REPORT if the latched last flag is set, else IDLE.
- REPORT: out_valid = 1; out_min, out_max and out_count are stable. On out_ready, go to IDLE and set the first flag.
- Comparisons are strict, so ties never update min or max.
- Comparator semantics: lt = (a < b), eq = (a == b). Greater is !lt && !eq.
- A sample presented with in_valid outside IDLE is not consumed. in_ready = 0 in that case.

## Timing
- Reset values:
  - Outputs: in_ready = 1, out_valid = 0, out_min = 0, out_max = 0, out_count = 0.
  - Internal: state IDLE, first flag = 1.
- Throughput:
  - First sample of a frame: 1 cycle.
  - Each later sample: 3 cycles (IDLE accept, CMP_MIN, CMP_MAX).
- Latency:
  - Single-sample frame: accept at edge k gives out_valid high from edge k+1.
  - Otherwise: last sample accepted at edge k gives out_valid high from edge k+3.
- out_valid and the data outputs are registered. They hold while out_ready = 0.
- The result handshake completes on the edge where out_valid && out_ready. in_ready is high in the following cycle.
- Counter saturation: the count stays at max. min and max tracking continues unaffected.
- Reset mid-frame or mid-REPORT:
  - The frame is discarded and all values above are restored.
  - There is no partial out_valid.
- rst has priority over every other condition on the same edge.

## Configuration
- CMP_MINMAX_IDX_EN defined:
  - Adds ports out_min_idx and out_max_idx (output, CNT_W each). These give the 0-based position of the first occurrence of the min and max.
  - Both are updated on the same conditions as min and max. Both reset to 0 and saturate with the counter.
- CMP_MINMAX_IDX_EN undefined: the ports and index registers are absent. All other behaviour is identical.

## Structure
- Package cmp_minmax_pkg holds:
  - the state enum (IDLE, CMP_MIN, CMP_MAX, REPORT);
  - default WIDTH and CNT_W constants.
- Sub-module cmp_core:
  - Combinational, WIDTH-parameterised, outputs lt and eq.
  - Exactly one instance, with operand muxing driven by the FSM.
  - It is the shared resource; no second comparator is permitted.

## Test plan
- Frame 5, 3, 9, 3 (last), out_ready = 1 → out_min = 3, out_max = 9, out_count = 4. With IDX: min_idx = 1, max_idx = 2.
- Single sample 7 with in_last, accepted at edge k → out_valid at k+1, min = max = 7, count = 1.
- Frame 4, 4, 4 (last) → min = max = 4, count = 3. With IDX: both indices 0 (ties do not update).
- Frame 2, 8 (last), with out_ready held low 5 cycles:
  - out_valid stays 1 and data is stable at min = 2, max = 8, count = 2; in_ready = 0.
  - Releasing out_ready completes the handshake; in_ready = 1 in the next cycle.
- CNT_W = 2, frame of 5 samples 1, 2, 3, 4, 0 (last) → count = 3, min = 0, max = 4.
- Reset asserted in CMP_MAX mid-frame, then frame 6 (last) → result min = max = 6, count = 1, with no stale values from the aborted frame.
